battleship_game_core: RTL and testbench
=======================================

Name: battleship_game_core

Overview:
- Parametrised game engine for the Battleship VGA lab: owns both boards, cursor, ship placement, turn sequencing, PC opponent and turn timer.
- Generalises the fixed 5x5 / 5-ship top level to BOARD_N x BOARD_N with MAX_SHIPS ships.
- Adds PC auto-placement, PC firing, a per-turn timeout and a read port so the VGA renderer pulls cell codes instead of sharing the board arrays.
- Sits between the debounced buttons and the vga / 7-segment blocks.

Parameters:
BOARD_N, 5, board side length (2..8)
MAX_SHIPS, 5, upper clamp on ship count (1..BOARD_N*BOARD_N-1)
TURN_TICKS, 10, tick pulses the player gets per turn (>=1)
IDX_W, $clog2(BOARD_N), row/column index width (derived)
CNT_W, $clog2(MAX_SHIPS+1), ship counter width (derived)

Ports:
clk  in  1  system clock; the block's only clock
rst  in  1  synchronous, active-high reset
btn_up/btn_down/btn_left/btn_right  in  1 each  debounced levels; rising edge moves the cursor
btn_action  in  1  debounced level; rising edge places a ship or fires
confirm  in  1  debounced level; rising edge confirms the ship count or restarts after game over
ships_req  in  CNT_W  requested ship count
tick  in  1  one-cycle timer enable (e.g. 1 Hz)
rd_i, rd_j  in  IDX_W each  VGA read address
rd_player_cell  out  2  player board cell at (rd_i, rd_j); combinational
rd_pc_cell  out  2  PC board cell at (rd_i, rd_j); SHIP is masked to EMPTY
cur_i, cur_j  out  IDX_W each  cursor row/column
state  out  3  FSM state code
ships_target  out  CNT_W  clamped ship count
player_left, pc_left  out  CNT_W each  unsunk ships per side
time_left  out  $clog2(TURN_TICKS+1)  remaining player ticks
victory, defeat  out  1 each  game result flags

Behaviour:
- Cell codes: 0 EMPTY, 1 SHIP, 2 MISS, 3 HIT.
- State codes: DECIDE=0, PLACE=1, PC_PLACE=2, PLAYER_TURN=3, PC_TURN=4, WIN=5, LOSE=6.
- Reset:
  - state DECIDE; all cells EMPTY; cursor (0,0).
  - ships_target, player_left, pc_left, time_left = 0; victory = defeat = 0.
  - LFSR = 16'hACE1; edge-detect registers = 0.
  - Reset asserted mid-game aborts at once, with no partial update.
- Inputs: all button and confirm edges are registered; one event per press; a held button has no further effect. Edge events take effect on the cycle after the edge.
- Cursor:
  - Moves in PLACE and PLAYER_TURN only.
  - up: i-1, down: i+1, left: j-1, right: j+1.
  - up and down together: up wins. left and right together: left wins.
  - Vertical and horizontal moves in the same cycle are both applied.
  - At an edge the cursor saturates (see the optional feature).
- DECIDE: on confirm, ships_target = clamp(ships_req, 1, MAX_SHIPS), player_left = 0, then go to PLACE.
- PLACE:
  - action on an EMPTY player cell sets it to SHIP and increments player_left. Action on a SHIP cell is ignored.
  - When player_left == ships_target, go to PC_PLACE.
- PC_PLACE:
  - On entry, probe = LFSR mod BOARD_N^2.
  - Each cycle: if the PC cell at probe is EMPTY, set it to SHIP, increment pc_left and reload probe from the LFSR. Otherwise probe = (probe+1) mod BOARD_N^2.
  - When pc_left == ships_target, go to PLAYER_TURN and set time_left = TURN_TICKS.
- PLAYER_TURN:
  - action on PC cell EMPTY writes MISS; on SHIP writes HIT and decrements pc_left.
  - action on MISS or HIT is ignored; the turn continues.
  - After a valid shot: WIN if pc_left becomes 0, else PC_TURN.
  - tick decrements time_left. When it reaches 0, go to PC_TURN with no shot.
  - A valid action and the final tick in the same cycle: the action wins and the shot counts.
- PC_TURN:
  - probe is loaded from the LFSR on entry.
  - Each cycle: if the player cell at probe is EMPTY or SHIP, fire (write MISS or HIT; HIT decrements player_left). Otherwise probe = (probe+1) mod BOARD_N^2.
  - After firing: LOSE if player_left becomes 0, else PLAYER_TURN with time_left reloaded.
  - Firing completes in at most BOARD_N^2 cycles.
- WIN / LOSE:
  - victory = 1 in WIN, defeat = 1 in LOSE; boards frozen.
  - On confirm: clear both boards and all counters, then go to DECIDE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every cycle regardless of state.

Optional Feature:
CURSOR_WRAP_EN:
- Defined: the cursor wraps at the edges (0-1 -> BOARD_N-1, BOARD_N-1+1 -> 0).
- Undefined: the cursor saturates at 0 and BOARD_N-1.

Test Plan:
- rst held 2 cycles mid PLAYER_TURN -> state 0, all rd cells 0, cursor (0,0), victory = defeat = 0 on the next cycle.
- ships_req=7 with MAX_SHIPS=5, confirm -> ships_target=5. ships_req=0 -> ships_target=1.
- PLACE target 2: action at (0,0) twice, move right, action -> player_left=2, exactly 2 SHIP cells, state 2; within 64 cycles pc_left=2 and state 3.
- PLAYER_TURN with no action, 10 ticks -> time_left 10→0, state 4; PC shot lands on an unshot cell within 25 cycles; state 3 and time_left=10.
- Action on the last PC ship, coinciding with the final tick -> HIT written, pc_left=0, state 5, victory=1; confirm -> state 0, boards cleared.
- With CURSOR_WRAP_EN: at (0,0), press up -> (4,0). Without it -> (0,0). Up+down pressed together -> i decrements.

Source files
------------

// File: rtl/battleship_game_core.sv
// battleship_game_core: board, cursor, placement, turn sequencing, PC opponent
// and turn timer for the Battleship VGA lab. Boards are read by the renderer
// through the rd_* port; the PC board read hides unsunk ships.
// Optional build macro: CURSOR_WRAP_EN (cursor wraps at board edges instead of
// saturating).
//
// state       | meaning
// DECIDE      | waiting for confirm to latch the clamped ship count
// PLACE       | player places ships with cursor + action
// PC_PLACE    | PC drops its ships at LFSR-seeded probe positions
// PLAYER_TURN | player fires at the PC board, turn timer running
// PC_TURN     | PC scans from an LFSR probe to the first unshot cell, fires
// WIN         | all PC ships sunk; boards frozen until confirm
// LOSE        | all player ships sunk; boards frozen until confirm
module battleship_game_core #(
   parameter int BOARD_N    = 5,
   parameter int MAX_SHIPS  = 5,
   parameter int TURN_TICKS = 10,
   parameter int IDX_W      = $clog2(BOARD_N),
   parameter int CNT_W      = $clog2(MAX_SHIPS+1)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              btn_up,
   input  logic                              btn_down,
   input  logic                              btn_left,
   input  logic                              btn_right,
   input  logic                              btn_action,
   input  logic                              confirm,
   input  logic [CNT_W-1:0]                  ships_req,
   input  logic                              tick,
   input  logic [IDX_W-1:0]                  rd_i,
   input  logic [IDX_W-1:0]                  rd_j,
   output logic [1:0]                        rd_player_cell,
   output logic [1:0]                        rd_pc_cell,
   output logic [IDX_W-1:0]                  cur_i,
   output logic [IDX_W-1:0]                  cur_j,
   output logic [2:0]                        state,
   output logic [CNT_W-1:0]                  ships_target,
   output logic [CNT_W-1:0]                  player_left,
   output logic [CNT_W-1:0]                  pc_left,
   output logic [$clog2(TURN_TICKS+1)-1:0]   time_left,
   output logic                              victory,
   output logic                              defeat
);

   localparam int CELLS = BOARD_N * BOARD_N;
   localparam int PW    = $clog2(CELLS);
   localparam int TW    = $clog2(TURN_TICKS+1);

   localparam logic [PW-1:0]    N_P     = PW'(BOARD_N);
   localparam logic [PW-1:0]    LAST_P  = PW'(CELLS-1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BOARD_N-1);
   localparam logic [15:0]      CELLS16 = 16'(CELLS);
   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_SHIPS);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [TW-1:0]    TT      = TW'(TURN_TICKS);

   localparam logic [1:0] C_EMPTY = 2'd0;
   localparam logic [1:0] C_SHIP  = 2'd1;
   localparam logic [1:0] C_MISS  = 2'd2;
   localparam logic [1:0] C_HIT   = 2'd3;

   typedef enum logic [2:0] {
      S_DECIDE   = 3'd0,
      S_PLACE    = 3'd1,
      S_PC_PLACE = 3'd2,
      S_PLAYER   = 3'd3,
      S_PC_TURN  = 3'd4,
      S_WIN      = 3'd5,
      S_LOSE     = 3'd6
   } state_t;

   state_t st, st_n;

   logic [1:0]       player_board [CELLS];
   logic [1:0]       pc_board     [CELLS];
   logic [15:0]      lfsr, lfsr_n;
   logic [PW-1:0]    probe, probe_next, lfsr_mod, cur_idx, rd_idx;
   logic [5:0]       btn_now, btn_prev, btn_edge;
   logic             up_e, down_e, left_e, right_e, act_e, conf_e;
   logic [IDX_W-1:0] ci_n, cj_n;
   logic [1:0]       player_at_cur, pc_at_cur, player_at_probe, pc_at_probe;
   logic [1:0]       pc_raw;
   logic             rd_in_range;
   logic [CNT_W-1:0] clamped;
   logic             decide_go, place_wr, pcplace_wr, probe_load, probe_step;
   logic             shot, tick_dec, time_reload, pc_fire, clear_all, cursor_en;

   function automatic logic [PW-1:0] cell_idx(input logic [IDX_W-1:0] i,
                                              input logic [IDX_W-1:0] j);
      return PW'(i) * N_P + PW'(j);
   endfunction

   function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] v);
`ifdef CURSOR_WRAP_EN
      return (v == '0) ? IDX_MAX : v - IDX_W'(1);
`else
      return (v == '0) ? '0 : v - IDX_W'(1);
`endif
   endfunction

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
`ifdef CURSOR_WRAP_EN
      return (v == IDX_MAX) ? '0 : v + IDX_W'(1);
`else
      return (v == IDX_MAX) ? IDX_MAX : v + IDX_W'(1);
`endif
   endfunction

   assign btn_now = {confirm, btn_action, btn_right, btn_left, btn_down, btn_up};
   assign up_e    = btn_edge[0];
   assign down_e  = btn_edge[1];
   assign left_e  = btn_edge[2];
   assign right_e = btn_edge[3];
   assign act_e   = btn_edge[4];
   assign conf_e  = btn_edge[5];

   assign lfsr_n     = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   assign lfsr_mod   = PW'(lfsr % CELLS16);
   assign probe_next = (probe == LAST_P) ? '0 : probe + PW'(1);

   assign cur_idx         = cell_idx(cur_i, cur_j);
   assign player_at_cur   = player_board[cur_idx];
   assign pc_at_cur       = pc_board[cur_idx];
   assign player_at_probe = player_board[probe];
   assign pc_at_probe     = pc_board[probe];

   assign clamped = (ships_req == '0)   ? ONE_C :
                    (ships_req > MAX_C) ? MAX_C : ships_req;

   assign state   = st;
   assign victory = (st == S_WIN);
   assign defeat  = (st == S_LOSE);

   // Renderer read port; out-of-board addresses read as EMPTY, PC ships hidden.
   always_comb begin
      rd_in_range    = (rd_i <= IDX_MAX) && (rd_j <= IDX_MAX);
      rd_idx         = cell_idx(rd_i, rd_j);
      rd_player_cell = C_EMPTY;
      pc_raw         = C_EMPTY;
      if (rd_in_range) begin
         rd_player_cell = player_board[rd_idx];
         pc_raw         = pc_board[rd_idx];
      end
      rd_pc_cell = (pc_raw == C_SHIP) ? C_EMPTY : pc_raw;
   end

   // Next cursor position: up beats down, left beats right, axes independent.
   always_comb begin
      ci_n = cur_i;
      cj_n = cur_j;
      if (up_e)         ci_n = idx_dec(cur_i);
      else if (down_e)  ci_n = idx_inc(cur_i);
      if (left_e)       cj_n = idx_dec(cur_j);
      else if (right_e) cj_n = idx_inc(cur_j);
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      st_n        = st;
      decide_go   = 1'b0;
      place_wr    = 1'b0;
      pcplace_wr  = 1'b0;
      probe_load  = 1'b0;
      probe_step  = 1'b0;
      shot        = 1'b0;
      tick_dec    = 1'b0;
      time_reload = 1'b0;
      pc_fire     = 1'b0;
      clear_all   = 1'b0;
      cursor_en   = 1'b0;
      unique case (st)
         S_DECIDE: begin
            if (conf_e) begin
               decide_go = 1'b1;
               st_n      = S_PLACE;
            end
         end
         S_PLACE: begin
            cursor_en = 1'b1;
            if (player_left == ships_target) begin
               st_n       = S_PC_PLACE;
               probe_load = 1'b1;
            end else if (act_e && player_at_cur == C_EMPTY) begin
               place_wr = 1'b1;
            end
         end
         S_PC_PLACE: begin
            if (pc_left == ships_target) begin
               st_n        = S_PLAYER;
               time_reload = 1'b1;
            end else if (pc_at_probe == C_EMPTY) begin
               pcplace_wr = 1'b1;
            end else begin
               probe_step = 1'b1;
            end
         end
         S_PLAYER: begin
            cursor_en = 1'b1;
            // A valid shot takes priority over a coincident final tick.
            if (act_e && !pc_at_cur[1]) begin
               shot       = 1'b1;
               probe_load = 1'b1;
               st_n       = (pc_at_cur == C_SHIP && pc_left == ONE_C) ? S_WIN : S_PC_TURN;
            end else if (tick && time_left != '0) begin
               tick_dec = 1'b1;
               if (time_left == TW'(1)) begin
                  st_n       = S_PC_TURN;
                  probe_load = 1'b1;
               end
            end
         end
         S_PC_TURN: begin
            if (!player_at_probe[1]) begin
               pc_fire     = 1'b1;
               time_reload = 1'b1;
               st_n        = (player_at_probe == C_SHIP && player_left == ONE_C) ? S_LOSE : S_PLAYER;
            end else begin
               probe_step = 1'b1;
            end
         end
         S_WIN, S_LOSE: begin
            if (conf_e) begin
               clear_all = 1'b1;
               st_n      = S_DECIDE;
            end
         end
         default: st_n = S_DECIDE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) st <= S_DECIDE;
      else     st <= st_n;
   end

   // Free-running LFSR and button edge registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr     <= 16'hACE1;
         btn_prev <= '0;
         btn_edge <= '0;
      end else begin
         lfsr     <= lfsr_n;
         btn_prev <= btn_now;
         btn_edge <= btn_now & ~btn_prev;
      end
   end

   // Boards, counters, cursor, probe and turn timer.
   always_ff @(posedge clk) begin
      if (rst || clear_all) begin
         for (int k = 0; k < CELLS; k++) begin
            player_board[k] <= C_EMPTY;
            pc_board[k]     <= C_EMPTY;
         end
         cur_i        <= '0;
         cur_j        <= '0;
         probe        <= '0;
         ships_target <= '0;
         player_left  <= '0;
         pc_left      <= '0;
         time_left    <= '0;
      end else begin
         if (cursor_en) begin
            cur_i <= ci_n;
            cur_j <= cj_n;
         end
         if (decide_go) begin
            ships_target <= clamped;
            player_left  <= '0;
         end
         if (place_wr) begin
            player_board[cur_idx] <= C_SHIP;
            player_left           <= player_left + ONE_C;
         end
         if (pcplace_wr) begin
            pc_board[probe] <= C_SHIP;
            pc_left         <= pc_left + ONE_C;
         end
         if (probe_load || pcplace_wr) probe <= lfsr_mod;
         else if (probe_step)          probe <= probe_next;
         if (shot) begin
            pc_board[cur_idx] <= (pc_at_cur == C_SHIP) ? C_HIT : C_MISS;
            if (pc_at_cur == C_SHIP) pc_left <= pc_left - ONE_C;
         end
         if (pc_fire) begin
            player_board[probe] <= (player_at_probe == C_SHIP) ? C_HIT : C_MISS;
            if (player_at_probe == C_SHIP) player_left <= player_left - ONE_C;
         end
         if (time_reload)   time_left <= TT;
         else if (tick_dec) time_left <= time_left - TW'(1);
      end
   end

endmodule

// File: tb/tb_battleship_game_core.sv
// Directed bench for battleship_game_core (default parameters, 5x5 board).
module tb_battleship_game_core;

   localparam int N = 5;
   localparam logic [5:0] B_UP    = 6'b000001;
   localparam logic [5:0] B_DOWN  = 6'b000010;
   localparam logic [5:0] B_LEFT  = 6'b000100;
   localparam logic [5:0] B_RIGHT = 6'b001000;
   localparam logic [5:0] B_ACT   = 6'b010000;
   localparam logic [5:0] B_CONF  = 6'b100000;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up, btn_down, btn_left, btn_right, btn_action, confirm, tick;
   logic [2:0] ships_req;
   logic [2:0] rd_i, rd_j;
   logic [1:0] rd_player_cell, rd_pc_cell;
   logic [2:0] cur_i, cur_j, st_o;
   logic [2:0] ships_target, player_left, pc_left;
   logic [3:0] time_left;
   logic       victory, defeat;

   int n_assert = 0;
   int n_fail   = 0;
   int p_ship, p_shot, p_hit, p_nz, c_nz;
   int pos, ti, tj;

   logic [15:0] lfsr_m, lfsr_prev;

   battleship_game_core dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .btn_action(btn_action), .confirm(confirm), .ships_req(ships_req), .tick(tick),
      .rd_i(rd_i), .rd_j(rd_j), .rd_player_cell(rd_player_cell), .rd_pc_cell(rd_pc_cell),
      .cur_i(cur_i), .cur_j(cur_j), .state(st_o), .ships_target(ships_target),
      .player_left(player_left), .pc_left(pc_left), .time_left(time_left),
      .victory(victory), .defeat(defeat)
   );

   always #50 clk = ~clk;

   // Reference LFSR: seed ACE1, Galois x^16+x^14+x^13+x^11+1, steps every cycle.
   always @(posedge clk) begin
      lfsr_prev <= lfsr_m;
      if (rst) lfsr_m <= 16'hACE1;
      else     lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [5:0] m);
      {confirm, btn_action, btn_right, btn_left, btn_down, btn_up} = m;
      @(negedge clk);
      {confirm, btn_action, btn_right, btn_left, btn_down, btn_up} = '0;
      @(negedge clk);
   endtask

   task automatic tick_once();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic scan();
      p_ship = 0; p_shot = 0; p_hit = 0; p_nz = 0; c_nz = 0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            rd_i = 3'(i);
            rd_j = 3'(j);
            #1;
            if (rd_player_cell != 2'd0) p_nz++;
            if (rd_player_cell == 2'd1) p_ship++;
            if (rd_player_cell >= 2'd2) p_shot++;
            if (rd_player_cell == 2'd3) p_hit++;
            if (rd_pc_cell != 2'd0)     c_nz++;
         end
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      for (int k = 0; k < budget && st_o != s; k++) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      {confirm, btn_action, btn_right, btn_left, btn_down, btn_up} = '0;
      tick = 1'b0; ships_req = '0; rd_i = '0; rd_j = '0;
      repeat (3) @(negedge clk);
      chk("reset_state", st_o, 0);
      chk("reset_cur_i", cur_i, 0);
      chk("reset_target", ships_target, 0);
      chk("reset_time", time_left, 0);
      chk("reset_flags", {victory, defeat}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Clamp high and cursor edge behaviour.
      ships_req = 3'd7;
      pulse(B_CONF);
      chk("clamp_hi", ships_target, 5);
      chk("decide_to_place", st_o, 1);
      pulse(B_UP);
`ifdef CURSOR_WRAP_EN
      chk("cursor_up_edge", cur_i, 4);
      pulse(B_DOWN);
`else
      chk("cursor_up_edge", cur_i, 0);
`endif
      pulse(B_DOWN);
      pulse(B_DOWN);
      chk("cursor_down2", cur_i, 2);
      pulse(B_UP | B_DOWN);
      chk("cursor_up_wins", cur_i, 1);
      pulse(B_LEFT | B_RIGHT);
`ifdef CURSOR_WRAP_EN
      chk("cursor_left_wins", cur_j, 4);
      pulse(B_DOWN | B_RIGHT);
      chk("cursor_diag_i", cur_i, 2);
      chk("cursor_diag_j", cur_j, 0);
`else
      chk("cursor_left_wins", cur_j, 0);
      pulse(B_DOWN | B_RIGHT);
      chk("cursor_diag_i", cur_i, 2);
      chk("cursor_diag_j", cur_j, 1);
`endif

      // Game 1: two ships, placement, PC placement, timeout, PC shot.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ships_req = 3'd2;
      pulse(B_CONF);
      chk("target_2", ships_target, 2);
      pulse(B_ACT);
      chk("place_first", player_left, 1);
      pulse(B_ACT);
      chk("place_dup_ignored", player_left, 1);
      pulse(B_RIGHT);
      chk("move_right", cur_j, 1);
      pulse(B_ACT);
      chk("place_second", player_left, 2);
      @(negedge clk);
      chk("enter_pc_place", st_o, 2);
      scan();
      chk("player_ship_cells", p_ship, 2);
      wait_state(3'd3, 64);
      chk("pc_place_done", st_o, 3);
      chk("pc_left_2", pc_left, 2);
      chk("time_loaded", time_left, 10);
      scan();
      chk("pc_ships_masked", c_nz, 0);
      tick_once();
      chk("time_9", time_left, 9);
      repeat (8) tick_once();
      chk("time_1", time_left, 1);
      chk("still_player", st_o, 3);
      tick_once();
      chk("time_0", time_left, 0);
      chk("timeout_pc_turn", st_o, 4);
      wait_state(3'd3, 25);
      chk("pc_turn_done", st_o, 3);
      chk("time_reload", time_left, 10);
      scan();
      chk("pc_one_shot", p_shot, 1);
      chk("player_left_vs_hits", player_left, 2 - p_hit);
      chk("player_ships_conserved", p_ship + p_hit, 2);

      // Reset held two cycles mid PLAYER_TURN.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_state", st_o, 0);
      chk("midrst_cursor", {cur_i, cur_j}, 0);
      chk("midrst_flags", {victory, defeat}, 0);
      chk("midrst_counts", {ships_target, player_left, pc_left}, 0);
      chk("midrst_time", time_left, 0);
      scan();
      chk("midrst_player_board", p_nz, 0);
      chk("midrst_pc_board", c_nz, 0);

      // Game 2: clamp low to one ship, sink it on the final tick.
      ships_req = 3'd0;
      pulse(B_CONF);
      chk("clamp_lo", ships_target, 1);
      pulse(B_ACT);
      chk("g2_place", player_left, 1);
      @(negedge clk);
      chk("g2_pc_place", st_o, 2);
      pos = int'(lfsr_prev % 16'd25);
      ti = pos / N;
      tj = pos % N;
      wait_state(3'd3, 64);
      chk("g2_player_turn", st_o, 3);
      chk("g2_pc_left", pc_left, 1);
      repeat (ti) pulse(B_DOWN);
      repeat (tj) pulse(B_RIGHT);
      chk("g2_cursor_i", cur_i, ti);
      chk("g2_cursor_j", cur_j, tj);
      rd_i = 3'(ti); rd_j = 3'(tj);
      #1;
      chk("g2_ship_hidden", rd_pc_cell, 0);
      repeat (9) tick_once();
      chk("g2_time_1", time_left, 1);
      btn_action = 1'b1;
      @(negedge clk);
      btn_action = 1'b0;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("g2_win_state", st_o, 5);
      chk("g2_victory", {victory, defeat}, 2'b10);
      chk("g2_pc_left_0", pc_left, 0);
      rd_i = 3'(ti); rd_j = 3'(tj);
      #1;
      chk("g2_hit_written", rd_pc_cell, 3);
      pulse(B_CONF);
      chk("restart_state", st_o, 0);
      chk("restart_flags", {victory, defeat}, 0);
      chk("restart_counts", {ships_target, player_left, pc_left}, 0);
      scan();
      chk("restart_player_board", p_nz, 0);
      chk("restart_pc_board", c_nz, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
